// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encodings and control-vector layout for the multicycle MIPS controller.
// Pure definitions: no latency or flow-control behaviour lives here.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

  // An instruction completes on the edge that leaves one of these states.
  function automatic logic is_retiring(input state_t s, input logic mem_ready);
    case (s)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: return 1'b1;
      S_MEMWRITE:                                   return mem_ready;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_state_outputs.sv
// Combinational state -> control-vector decode; zero latency, no handshake.
// FETCH's irwrite/pcwrite are raw here and get mem_ready-gated by the caller.
module mc_state_outputs
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE:   ctrl.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMREAD:  ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = PCSRC_ALUOUT;
      end
      S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB:   ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: 3-5 cycles per instruction, one extra cycle per mem_ready-low cycle.
// FETCH, MEMREAD and MEMWRITE hold until mem_ready; counts retired instructions.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             irwrite,
  output logic             pc_en,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             memwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t cur_state, nxt_state;
  ctrl_t  ctrl;
  logic   fetch_gate;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_RESET;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = cur_state;
    illegal_op = 1'b0;
    case (cur_state)
      S_RESET:    nxt_state = S_FETCH;
      S_FETCH:    if (mem_ready) nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXECUTE;
          OP_BEQ:       nxt_state = S_BRANCH;
          OP_ADDI:      nxt_state = S_ADDIEXEC;
          OP_J:         nxt_state = S_JUMP;
          default: begin
            nxt_state  = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      nxt_state = S_MEMREAD;
        else if (op == OP_SW) nxt_state = S_MEMWRITE;
        else                  nxt_state = S_FETCH;
      end
      S_MEMREAD:  if (mem_ready) nxt_state = S_MEMWB;
      S_MEMWRITE: if (mem_ready) nxt_state = S_FETCH;
      S_EXECUTE:  nxt_state = S_ALUWB;
      S_ADDIEXEC: nxt_state = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: nxt_state = S_FETCH;
      default:    nxt_state = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               retired <= '0;
    else if (is_retiring(cur_state, mem_ready)) retired <= retired + 1'b1;
  end

  mc_state_outputs u_dec (
    .state (cur_state),
    .ctrl  (ctrl)
  );

  // Only the FETCH strobes wait on memory; JUMP's pcwrite is unconditional.
  assign fetch_gate = (cur_state == S_FETCH) ? mem_ready : 1'b1;

  assign iord     = ctrl.iord;
  assign irwrite  = ctrl.irwrite & fetch_gate;
  assign pc_en    = (ctrl.pcwrite & fetch_gate) | (ctrl.branch & zero);
  assign regwrite = ctrl.regwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign memwrite = ctrl.memwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;
  assign state    = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: steps each instruction class state by state.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = 6'b000000;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        iord, irwrite, pc_en, regwrite, regdst, memtoreg, memwrite, alusrca;
  logic [1:0]  alusrcb, aluop, pcsrc;
  logic        illegal_op;
  logic [31:0] retired;
  logic [3:0]  state;

  int n_asserts = 0;
  int n_fails   = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .pc_en(pc_en), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .memwrite(memwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .illegal_op(illegal_op),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;

    // Reset state: every output low
    step(); step();
    chk("rst_state", 32'(state), 32'(S_RESET));
    chk("rst_outs", {20'b0, iord, irwrite, pc_en, regwrite, regdst, memtoreg, memwrite,
                     alusrca, alusrcb, aluop, pcsrc, illegal_op} >> 1, 32'h0);
    chk("rst_ill", 32'(illegal_op), 0);
    chk("rst_retired", retired, 0);
    reset = 1'b0;

    // R-type add
    step();
    chk("add_fetch", 32'(state), 32'(S_FETCH));
    chk("add_fetch_ctl", {29'b0, irwrite, pc_en, alusrcb == SRCB_FOUR}, 32'h7);
    step();
    chk("add_decode", 32'(state), 32'(S_DECODE));
    chk("add_dec_srcb", 32'(alusrcb), 32'(2'b11));
    step();
    chk("add_exec", 32'(state), 32'(S_EXECUTE));
    chk("add_exec_ctl", {29'b0, alusrca, aluop}, {29'b0, 1'b1, 2'b10});
    step();
    chk("add_aluwb", 32'(state), 32'(S_ALUWB));
    chk("add_wb_ctl", {30'b0, regwrite, regdst}, 32'h3);
    chk("add_ret_pre", retired, 0);
    step();
    chk("add_back", 32'(state), 32'(S_FETCH));
    chk("add_ret", retired, 1);

    // lw with two wait cycles in MEMREAD: 7 cycles total
    op = OP_LW;
    n = 1;
    step(); n++;
    chk("lw_decode", 32'(state), 32'(S_DECODE));
    step(); n++;
    chk("lw_memadr", 32'(state), 32'(S_MEMADR));
    chk("lw_adr_ctl", {29'b0, alusrca, alusrcb}, {29'b0, 1'b1, 2'b10});
    step(); n++;
    mem_ready = 1'b0;
    chk("lw_rd1", 32'(state), 32'(S_MEMREAD));
    chk("lw_rd1_iord", 32'(iord), 1);
    step(); n++;
    chk("lw_rd2", 32'(state), 32'(S_MEMREAD));
    step(); n++;
    chk("lw_rd3", 32'(state), 32'(S_MEMREAD));
    chk("lw_rd3_iord", 32'(iord), 1);
    mem_ready = 1'b1;
    step(); n++;
    chk("lw_memwb", 32'(state), 32'(S_MEMWB));
    chk("lw_wb_ctl", {29'b0, memtoreg, regwrite, regdst}, 32'h6);
    step();
    chk("lw_back", 32'(state), 32'(S_FETCH));
    chk("lw_cycles", n, 7);
    chk("lw_ret", retired, 2);

    // beq taken, with a FETCH stall first
    op = OP_BEQ;
    mem_ready = 1'b0;
    #1;
    chk("fetch_stall_ctl", {30'b0, irwrite, pc_en}, 0);
    step();
    chk("fetch_hold", 32'(state), 32'(S_FETCH));
    mem_ready = 1'b1;
    step();
    chk("beq1_decode", 32'(state), 32'(S_DECODE));
    zero = 1'b1;
    step();
    chk("beq1_branch", 32'(state), 32'(S_BRANCH));
    chk("beq1_ctl", {27'b0, pc_en, pcsrc, aluop}, {27'b0, 1'b1, 2'b01, 2'b01});
    step();
    chk("beq1_ret", retired, 3);

    // beq not taken
    zero = 1'b0;
    step(); step();
    chk("beq0_branch", 32'(state), 32'(S_BRANCH));
    chk("beq0_pcen", 32'(pc_en), 0);
    step();
    chk("beq0_ret", retired, 4);

    // sw with memory wait
    op = OP_SW;
    step(); step(); step();
    chk("sw_memwrite", 32'(state), 32'(S_MEMWRITE));
    mem_ready = 1'b0;
    #1;
    chk("sw_ctl_wait", {29'b0, memwrite, iord, regwrite}, 32'h6);
    step();
    chk("sw_hold", 32'(state), 32'(S_MEMWRITE));
    chk("sw_hold_ctl", {30'b0, memwrite, regwrite}, 32'h2);
    chk("sw_ret_pre", retired, 4);
    mem_ready = 1'b1;
    step();
    chk("sw_back", 32'(state), 32'(S_FETCH));
    chk("sw_ret", retired, 5);

    // Illegal opcode
    op = 6'b111111;
    step();
    chk("ill_pulse", 32'(illegal_op), 1);
    step();
    chk("ill_back", 32'(state), 32'(S_FETCH));
    chk("ill_clear", 32'(illegal_op), 0);
    chk("ill_ret", retired, 5);

    // Jump
    op = OP_J;
    step(); step();
    chk("j_state", 32'(state), 32'(S_JUMP));
    chk("j_ctl", {29'b0, pc_en, pcsrc}, {29'b0, 1'b1, 2'b10});
    step();
    chk("j_ret", retired, 6);

    // addi: bounded cycle count back to FETCH
    op = OP_ADDI;
    n = 0;
    do begin
      step();
      n++;
      if (state == S_ADDIWB) chk("addi_wb_ctl", {30'b0, regwrite, regdst}, 32'h2);
    end while (state != S_FETCH && n < 20);
    chk("addi_cycles", n, 4);
    chk("addi_ret", retired, 7);

    // Asynchronous reset in the middle of a MEMWRITE wait
    op = OP_SW;
    step(); step(); step();
    chk("rst_sw_state", 32'(state), 32'(S_MEMWRITE));
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_state", 32'(state), 32'(S_RESET));
    chk("rst_async_mw", 32'(memwrite), 0);
    chk("rst_async_ret", retired, 0);
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    op = OP_RTYPE;
    step();
    chk("rst_refetch", 32'(state), 32'(S_FETCH));
    chk("rst_refetch_ir", 32'(irwrite), 1);
    step(); step(); step(); step();
    chk("rst_r_back", 32'(state), 32'(S_FETCH));
    chk("rst_r_ret", retired, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
